// File: rtl/game_ctl.sv
// Game sequencer: START/PLAY/WIN/LOSE flow, door latch, restart pulse and seconds countdown.
// Optional countdown/LOSE path is built only when GAME_CTL_TIMEOUT_EN is defined.
module game_ctl #(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned TIME_LIMIT     = 99,
    parameter int unsigned START_HOLD     = 30,
    parameter logic [11:0] GOAL_X         = 12'd700,
    parameter logic [11:0] GOAL_Y         = 12'd500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_tick,
    input  logic        m_left1,
    input  logic        m_right1,
    input  logic        gpio_left,
    input  logic        gpio_right,
    input  logic [1:0]  button_pressed,
    input  logic [11:0] xpos_player1,
    input  logic [11:0] ypos_player1,
    input  logic [11:0] xpos_player2,
    input  logic [11:0] ypos_player2,
    output logic [1:0]  game_state,
    output logic        door_open,
    output logic        restart,
    output logic [7:0]  time_left
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_WIN   = 2'd2;
    localparam logic [1:0] ST_LOSE  = 2'd3;

    localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
`ifdef GAME_CTL_TIMEOUT_EN
    localparam int unsigned FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
`endif

    if (TIME_LIMIT < 1 || TIME_LIMIT > 255 || FRAMES_PER_SEC < 1 || START_HOLD < 1) begin : g_param_check
        $error("game_ctl: parameter out of range");
    end

    logic [1:0] left1_ff, right1_ff, left2_ff, right2_ff;
    logic       right1_d, right2_d;
    logic       right_edge_q;
    logic       v_tick_q;
    logic       tick_c;
    logic       win_c;
    logic       timeout_c;
    logic       entry_q;

    logic [1:0]        state_nxt;
    logic              door_nxt;
    logic              restart_nxt;
    logic [7:0]        time_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
`ifdef GAME_CTL_TIMEOUT_EN
    logic [FRAME_W-1:0] frame_cnt, frame_nxt;
`endif

    // Button synchronizers, right-button edge detect and frame-tick history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left1_ff     <= 2'b00;
            right1_ff    <= 2'b00;
            left2_ff     <= 2'b00;
            right2_ff    <= 2'b00;
            right1_d     <= 1'b0;
            right2_d     <= 1'b0;
            right_edge_q <= 1'b0;
            v_tick_q     <= 1'b0;
        end else begin
            left1_ff     <= {left1_ff[0], m_left1};
            right1_ff    <= {right1_ff[0], m_right1};
            left2_ff     <= {left2_ff[0], gpio_left};
            right2_ff    <= {right2_ff[0], gpio_right};
            right1_d     <= right1_ff[1];
            right2_d     <= right2_ff[1];
            right_edge_q <= (right1_ff[1] & ~right1_d) | (right2_ff[1] & ~right2_d);
            v_tick_q     <= v_tick;
        end
    end

    assign tick_c = v_tick & ~v_tick_q;
    assign win_c  = door_open
                  & (xpos_player1 >= GOAL_X) & (ypos_player1 >= GOAL_Y)
                  & (xpos_player2 >= GOAL_X) & (ypos_player2 >= GOAL_Y);

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_state <= ST_START;
            door_open  <= 1'b0;
            restart    <= 1'b0;
            time_left  <= 8'(TIME_LIMIT);
            hold_cnt   <= '0;
            entry_q    <= 1'b0;
`ifdef GAME_CTL_TIMEOUT_EN
            frame_cnt  <= '0;
`endif
        end else begin
            game_state <= state_nxt;
            door_open  <= door_nxt;
            restart    <= restart_nxt;
            time_left  <= time_nxt;
            hold_cnt   <= hold_nxt;
            entry_q    <= (state_nxt != game_state);
`ifdef GAME_CTL_TIMEOUT_EN
            frame_cnt  <= frame_nxt;
`endif
        end
    end

    // Next-state and next-output logic; entry_q blocks a second transition in an entry cycle
    always_comb begin
        state_nxt   = game_state;
        door_nxt    = door_open;
        restart_nxt = 1'b0;
        time_nxt    = time_left;
        hold_nxt    = hold_cnt;
        timeout_c   = 1'b0;
`ifdef GAME_CTL_TIMEOUT_EN
        frame_nxt   = frame_cnt;
`endif
        case (game_state)
            ST_START: begin
                if (!(left1_ff[1] & left2_ff[1])) begin
                    hold_nxt = '0;
                end else if (tick_c && !entry_q) begin
                    if (hold_cnt == HOLD_W'(START_HOLD - 1)) begin
                        state_nxt   = ST_PLAY;
                        restart_nxt = 1'b1;
                        time_nxt    = 8'(TIME_LIMIT);
                        door_nxt    = 1'b0;
                        hold_nxt    = '0;
`ifdef GAME_CTL_TIMEOUT_EN
                        frame_nxt   = '0;
`endif
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (button_pressed == 2'b11) begin
                    door_nxt = 1'b1;
                end
`ifdef GAME_CTL_TIMEOUT_EN
                if (tick_c) begin
                    if (frame_cnt == FRAME_W'(FRAMES_PER_SEC - 1)) begin
                        frame_nxt = '0;
                        if (time_left != 8'd0) begin
                            time_nxt  = time_left - 8'd1;
                            timeout_c = (time_left == 8'd1);
                        end
                    end else begin
                        frame_nxt = frame_cnt + FRAME_W'(1);
                    end
                end
`endif
                if (!entry_q) begin
                    if (win_c) begin
                        state_nxt = ST_WIN;
                    end else if (timeout_c) begin
                        state_nxt = ST_LOSE;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (right_edge_q && !entry_q) begin
                    state_nxt = ST_START;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

endmodule
